// File: rtl/console_writer.sv
// rtl/console_writer.sv - ASCII stream to text RAM writer with cursor, line feed and hardware scroll.
// Optional feature: define CONSOLE_TAB_EN for 8-column tab stops on 0x09.
module console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int CW   = $clog2(COLS),
  parameter int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_char,
  input  logic [23:0]   in_attr,
  output logic          in_ready,
  output logic          wr_en,
  output logic [RW-1:0] wr_row,
  output logic [CW-1:0] wr_col,
  output logic [31:0]   wr_data,
  output logic [RW-1:0] cursor_row,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] top_row
);

  typedef enum logic [1:0] {CLEAR_ALL = 2'd0, IDLE = 2'd1, CLEAR_ROW = 2'd2} state_t;

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  state_t        state_q, state_d;
  logic [RW-1:0] cur_row_q, cur_row_d, top_q, top_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [RW-1:0] clr_row_q, clr_row_d;
  logic [CW-1:0] clr_col_q, clr_col_d;
  logic [23:0]   clr_attr_q, clr_attr_d;
  logic          clr_last_q, clr_last_d;
  logic          wr_en_q, wr_en_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          do_lf, wrote;
  logic [RW:0]   phys_sum;
  logic [RW-1:0] phys_row;
`ifdef CONSOLE_TAB_EN
  int            tab_next;
`endif

  assign phys_sum = {1'b0, top_q} + {1'b0, cur_row_q};
  assign phys_row = (phys_sum >= (RW+1)'(ROWS)) ? RW'(phys_sum - (RW+1)'(ROWS)) : phys_sum[RW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CLEAR_ALL;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      top_q      <= '0;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      clr_attr_q <= '0;
      clr_last_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      top_q      <= top_d;
      clr_row_q  <= clr_row_d;
      clr_col_q  <= clr_col_d;
      clr_attr_q <= clr_attr_d;
      clr_last_q <= clr_last_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    top_d      = top_q;
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
    clr_attr_d = clr_attr_q;
    clr_last_d = clr_last_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_data_d  = wr_data_q;
    do_lf      = 1'b0;
    wrote      = 1'b0;
`ifdef CONSOLE_TAB_EN
    tab_next   = (int'(cur_col_q) / 8 + 1) * 8;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_row_d  = phys_row;
            wr_col_d  = cur_col_q;
            wr_data_d = {in_attr, in_char};
            wrote     = 1'b1;
            if (cur_col_q == COL_MAX) begin
              cur_col_d = '0;
              do_lf     = 1'b1;
            end else begin
              cur_col_d = cur_col_q + 1'b1;
            end
          end else begin
            case (in_char)
              8'h0A: do_lf = 1'b1;
              8'h0D: cur_col_d = '0;
              8'h08: if (cur_col_q != '0) cur_col_d = cur_col_q - 1'b1;
              8'h0C: begin
                // Cell (0,0) is written on the FF edge itself, so the sweep resumes at column 1.
                cur_row_d  = '0;
                cur_col_d  = '0;
                top_d      = '0;
                state_d    = CLEAR_ALL;
                clr_attr_d = in_attr;
                clr_row_d  = '0;
                clr_col_d  = CW'(1);
                clr_last_d = 1'b0;
                wr_en_d    = 1'b1;
                wr_row_d   = '0;
                wr_col_d   = '0;
                wr_data_d  = {in_attr, 8'h20};
              end
`ifdef CONSOLE_TAB_EN
              8'h09: begin
                if (tab_next >= COLS) begin
                  cur_col_d = '0;
                  do_lf     = 1'b1;
                end else begin
                  cur_col_d = CW'(tab_next);
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end
      default: begin
        // One extra cycle after the final clear write keeps in_ready low until the RAM port is free.
        if (clr_last_q) begin
          state_d    = IDLE;
          clr_last_d = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_row_d  = clr_row_q;
          wr_col_d  = clr_col_q;
          wr_data_d = {clr_attr_q, 8'h20};
          if (clr_col_q == COL_MAX) begin
            clr_col_d = '0;
            if (state_q == CLEAR_ROW || clr_row_q == ROW_MAX) clr_last_d = 1'b1;
            else clr_row_d = clr_row_q + 1'b1;
          end else begin
            clr_col_d = clr_col_q + 1'b1;
          end
        end
      end
    endcase

    if (do_lf) begin
      if (cur_row_q != ROW_MAX) begin
        cur_row_d = cur_row_q + 1'b1;
      end else begin
        // The old top row becomes the new bottom line and is blanked.
        top_d      = (top_q == ROW_MAX) ? '0 : top_q + 1'b1;
        state_d    = CLEAR_ROW;
        clr_row_d  = top_q;
        clr_attr_d = in_attr;
        clr_last_d = 1'b0;
        if (wrote) begin
          clr_col_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_row_d  = top_q;
          wr_col_d  = '0;
          wr_data_d = {in_attr, 8'h20};
          clr_col_d = CW'(1);
        end
      end
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign wr_en      = wr_en_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_data    = wr_data_q;
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;
  assign top_row    = top_q;

endmodule

// File: tb/tb_console_writer.sv
// tb/tb_console_writer.sv - randomized self-checking bench for console_writer against a cell-level model.
`timescale 1ns/1ps
module tb_console_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_char = 8'h00;
  logic [23:0]   in_attr = 24'h0;
  logic          in_ready, wr_en;
  logic [RW-1:0] wr_row, cursor_row, top_row;
  logic [CW-1:0] wr_col, cursor_col;
  logic [31:0]   wr_data;

  console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .in_attr(in_attr),
    .in_ready(in_ready), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .top_row(top_row)
  );

  always #5 clk = ~clk;

  typedef struct { int t; int row; int col; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t wlog[$];
  int  n_cmp = 0, n_bad = 0;
  int  cyc = 0, ready_at = 0;
  bit  start_pending = 1'b1;
  int  m_row = 0, m_col = 0, m_top = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_w(input int t, input int r, input int c, input logic [31:0] d);
    wr_t w;
    w.t = t; w.row = r; w.col = c; w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic model_lf(input logic [23:0] a, input int t0);
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int c = 0; c < COLS; c++) push_w(t0 + c, m_top, c, {a, 8'h20});
      m_top = (m_top + 1) % ROWS;
      ready_at = t0 + COLS;
    end
  endtask

  task automatic model_clear_all(input logic [23:0] a, input int t0);
    for (int i = 0; i < ROWS * COLS; i++) push_w(t0 + i, i / COLS, i % COLS, {a, 8'h20});
    ready_at = t0 + ROWS * COLS;
  endtask

  task automatic model_accept(input logic [7:0] ch, input logic [23:0] a, input int n);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push_w(n, (m_top + m_row) % ROWS, m_col, {a, ch});
      if (m_col < COLS - 1) m_col++;
      else begin m_col = 0; model_lf(a, n + 1); end
    end else if (ch == 8'h0A) model_lf(a, n);
    else if (ch == 8'h0D) m_col = 0;
    else if (ch == 8'h08) begin if (m_col > 0) m_col--; end
    else if (ch == 8'h0C) begin m_row = 0; m_col = 0; m_top = 0; model_clear_all(a, n); end
`ifdef CONSOLE_TAB_EN
    else if (ch == 8'h09) begin
      int nx;
      nx = (m_col / 8 + 1) * 8;
      if (nx >= COLS) begin m_col = 0; model_lf(a, n); end
      else m_col = nx;
    end
`endif
  endtask

  // Model advances on each rising edge; the cycle that follows edge k is cycle k.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      if (start_pending) begin
        start_pending = 1'b0;
        model_clear_all(24'h0, cyc + 1);
      end else if (in_valid && cyc >= ready_at) begin
        model_accept(in_char, in_attr, cyc + 1);
      end
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_row", wr_row, 0);
      chk("rst_wr_col", wr_col, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_cursor_row", cursor_row, 0);
      chk("rst_cursor_col", cursor_col, 0);
      chk("rst_top_row", top_row, 0);
      exp_q.delete();
      start_pending = 1'b1;
      m_row = 0; m_col = 0; m_top = 0; ready_at = 0;
    end else begin
      chk("in_ready", in_ready, (!start_pending && cyc >= ready_at) ? 1 : 0);
      chk("cursor_row", cursor_row, m_row);
      chk("cursor_col", cursor_col, m_col);
      chk("top_row", top_row, m_top);
      if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
        chk("wr_en", wr_en, 1);
        chk("wr_row", wr_row, exp_q[0].row);
        chk("wr_col", wr_col, exp_q[0].col);
        chk("wr_data", wr_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk("wr_en_idle", wr_en, 0);
      end
      if (wr_en) begin
        wr_t o;
        o.t = cyc; o.row = int'(wr_row); o.col = int'(wr_col); o.data = wr_data;
        wlog.push_back(o);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(input int bound);
    int w = 0;
    while (!in_ready && w < bound) begin @(posedge clk); #1; w++; end
    if (w >= bound) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] c, input logic [23:0] a);
    in_valid = 1'b1; in_char = c; in_attr = a;
    wait_ready(5000);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int bad, cnt, ff_used, r, prev_top;
    bit seen [ROWS][COLS];
    logic [7:0] ch;

    idle(3);
    rst = 1'b1;
    idle(100);
    rst = 1'b0;                       // reset in the middle of the power-up clear
    idle(3);
    rst = 1'b1;
    wlog.delete();
    wait_ready(3000);

    // Full clear: every cell once with a blank of attribute 0.
    chk("init_write_count", wlog.size(), ROWS * COLS);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) begin
      if (seen[wlog[i].row][wlog[i].col] || wlog[i].data != 32'h0000_0020) bad++;
      seen[wlog[i].row][wlog[i].col] = 1'b1;
    end
    chk("init_bad_cells", bad, 0);
    chk("init_in_ready", in_ready, 1);
    chk("init_cursor", {cursor_row, cursor_col}, 0);
    chk("init_top_row", top_row, 0);

    wlog.delete();
    send(8'h41, 24'h0F0000);
    send(8'h42, 24'h0F0000);
    idle(2);
    chk("ab_count", wlog.size(), 2);
    chk("ab_first", {wlog[0].row[7:0], wlog[0].col[7:0], wlog[0].data}, 48'h00_00_0F000041);
    chk("ab_second", {wlog[1].row[7:0], wlog[1].col[7:0], wlog[1].data}, 48'h00_01_0F000042);
    chk("ab_back_to_back", wlog[1].t - wlog[0].t, 1);
    chk("ab_cursor_col", cursor_col, 2);

    send(8'h0D, 24'h0); send(8'h0A, 24'h0); send(8'h08, 24'h0);
    idle(2);
    chk("crlfbs_cursor_row", cursor_row, 1);
    chk("crlfbs_cursor_col", cursor_col, 0);
    chk("crlfbs_no_writes", wlog.size(), 2);

    for (int i = 0; i < 28; i++) send(8'h0A, 24'h0);
    wlog.delete();
    send(8'h0A, 24'h00AB00);
    cnt = 0;
    while (!in_ready && cnt < 200) begin cnt++; @(posedge clk); #1; end
    chk("scroll_busy_cycles", cnt, 80);
    chk("scroll_write_count", wlog.size(), 80);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i].row != 0 || wlog[i].col != i || wlog[i].data != 32'h00AB_0020) bad++;
    chk("scroll_bad_cells", bad, 0);
    chk("scroll_top_row", top_row, 1);
    chk("scroll_cursor_row", cursor_row, 29);

    wlog.delete();
    for (int i = 0; i < 80; i++) begin
      ch = 8'h61 + 8'(i % 26);
      send(ch, 24'h123456);
    end
    send(8'h5A, 24'h654321);
    idle(2);
    chk("wrap_write_count", wlog.size(), 161);
    chk("wrap_last_col", {wlog[79].row[7:0], wlog[79].col[7:0]}, 16'h00_4F);
    chk("wrap_next_char", {wlog[160].row[7:0], wlog[160].col[7:0], wlog[160].data}, 48'h01_00_6543215A);
    chk("wrap_top_row", top_row, 2);

    send(8'h0D, 24'h0);
    for (int i = 0; i < 5; i++) send(8'h20, 24'h0);
    send(8'h09, 24'h0);
    idle(1);
`ifdef CONSOLE_TAB_EN
    chk("tab_col5", cursor_col, 8);
`else
    chk("tab_col5", cursor_col, 5);
`endif
    send(8'h0D, 24'h0);
    for (int i = 0; i < 77; i++) send(8'h20, 24'h0);
    prev_top = int'(top_row);
    send(8'h09, 24'h0);
    idle(1);
`ifdef CONSOLE_TAB_EN
    chk("tab_col77", cursor_col, 0);
    chk("tab_col77_top", top_row, (prev_top + 1) % ROWS);
`else
    chk("tab_col77", cursor_col, 77);
    chk("tab_col77_top", top_row, prev_top);
`endif

    ff_used = 0;
    for (int i = 0; i < 1200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      ch = 8'($urandom_range(32, 126));
      else if (r < 80) ch = 8'h0A;
      else if (r < 85) ch = 8'h0D;
      else if (r < 90) ch = 8'h08;
      else if (r < 94) ch = 8'h09;
      else if (r < 99) ch = 8'($urandom_range(0, 31));
      else if (ff_used == 0) begin ch = 8'h0C; ff_used = 1; end
      else ch = 8'h41;
      send(ch, 24'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    cnt = 0;
    while (exp_q.size() > 0 && cnt < 5000) begin @(posedge clk); #1; cnt++; end
    chk("end_expected_writes_drained", exp_q.size(), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/console_writer.md
# console_writer

Character-stream front end for the text console: accepts one ASCII character per handshake, interprets control codes, writes character cells into the text RAM and maintains the cursor position and hardware scroll offset consumed by the display controller. Sits directly upstream of the display controller: its write port drives the text RAM, and its cursor and top-row outputs feed the renderer.

## Interface
- COLS, 80, columns per screen (≥2)
- ROWS, 30, rows per screen (≥2)
- CW, $clog2(COLS), column index width (derived)
- RW, $clog2(ROWS), row index width (derived)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  character available
- in_char  in  8  ASCII code
- in_attr  in  24  cell attribute (fg/bg/flags), stored verbatim
- in_ready  out  1  character accepted when in_valid & in_ready
- wr_en  out  1  text RAM write strobe, one cell per cycle
- wr_row  out  RW  physical row of write
- wr_col  out  CW  column of write
- wr_data  out  32  cell = {attr[23:0], char[7:0]}
- cursor_row  out  RW  logical cursor row (0 = top of visible screen)
- cursor_col  out  CW  cursor column
- top_row  out  RW  physical row shown at screen line 0

## Operation
- Physical row = (top_row + logical row) mod ROWS; the renderer applies the same mapping.
- States: CLEAR_ALL, IDLE, CLEAR_ROW. in_ready = (state == IDLE), registered.
- IDLE, accepted char:
  - 0x20–0x7E: write {in_attr, char} at (cursor_row, cursor_col). If cursor_col < COLS-1: col+1. Else col=0 and line feed.
  - 0x0A LF: line feed. 0x0D CR: col=0. 0x08 BS: col−1 if col>0, no write.
  - 0x0C FF: cursor (0,0), top_row=0, enter CLEAR_ALL.
  - all other codes: accepted, no effect.
- Line feed: if cursor_row < ROWS-1: row+1. Else top_row = (top_row+1) mod ROWS, row stays ROWS-1, enter CLEAR_ROW on the new bottom physical row.
- CLEAR_ROW: COLS consecutive writes, col 0..COLS-1, data {attr of triggering char, 8'h20}; then IDLE.
- CLEAR_ALL: ROWS*COLS writes, row-major physical order from (0,0), data {24'h0, 8'h20} after reset, {attr of FF, 8'h20} after FF; then IDLE.
- Counters wrap modulo COLS/ROWS explicitly; no index ever reaches COLS or ROWS.

## Timing
- Reset values: in_ready 0, wr_en 0, wr_row/wr_col/wr_data 0, cursor_row/col 0, top_row 0, state CLEAR_ALL.
- First clock after reset release starts the full clear; in_ready rises after ROWS*COLS write cycles (2400 at defaults).
- Printable char: wr_en asserted the cycle after the acceptance edge, exactly 1 cycle; cursor outputs update on the acceptance edge.
- Back-to-back printables sustain 1 char/cycle with no bubbles.
- Wrap at last column on last row: char write cycle, then in_ready low for COLS cycles of clear; in_ready high again the cycle after the last clear write.
- CLEAR_ROW/CLEAR_ALL: wr_en continuously high, one cell per cycle; in_ready low throughout.
- Reset asserted mid-clear: all outputs return to reset values immediately; full clear restarts on release.

## Configuration
- CONSOLE_TAB_EN defined: 0x09 moves cursor_col to next multiple of 8, no write; if that is ≥ COLS, col=0 and line feed (scroll rule applies).
- Undefined: 0x09 is accepted and ignored like any other unhandled control code.

## Test plan
- Reset release -> 2400 writes of 32'h0000_0020 covering every (row,col) once, then in_ready=1, cursor (0,0), top_row 0.
- Send "AB" attr 24'h0F0000 -> writes 32'h0F000041 at (0,0) and 32'h0F000042 at (0,1) on consecutive cycles; cursor_col=2.
- CR, LF, BS at col 0 -> cursor (1,0) after CR+LF; BS leaves col 0; no writes.
- Fill 30 rows via 29 LFs then LF -> top_row 1, cursor_row 29, 80 writes of blank to physical row 0, in_ready low exactly 80 cycles.
- 80 printables on row 29 -> 80th writes col 79, then scroll clear; next char lands at physical row (top_row+29) mod 30, col 0.
- With CONSOLE_TAB_EN: col 5, TAB -> col 8; col 77, TAB -> col 0, next row. Without: TAB leaves col unchanged.
